// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small valid/ready FIFO; define UART_RX_PARITY_EN for 8E1 with PARITY_ERR_O
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BITRATE    = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_AW    = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       RX_I,
  output logic [7:0] DATA_O,
  output logic       VALID_O,
  input  logic       READY_I,
  output logic       FRAME_ERR_O,
`ifdef UART_RX_PARITY_EN
  output logic       PARITY_ERR_O,
`endif
  output logic       OVERRUN_O
);
  localparam int DIV   = CLK_HZ / (BITRATE * OVERSAMPLE);
  localparam int DW    = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TW    = $clog2(OVERSAMPLE);
  localparam int DEPTH = 2 ** FIFO_AW;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;
  state_t st_q, st_d;
  logic s1_q, s2_q, rx_s;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [2:0] bi_q, bi_d;
  logic [7:0] sh_q, sh_d;
  logic ferr_q, ferr_d, ovr_q, ovr_d;
  logic [7:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0] cnt_q;
  logic tick, mid, end_bit, push, pop, full, wr;
`ifdef UART_RX_PARITY_EN
  logic pbad_q, pbad_d, perr_q, perr_d;
  assign PARITY_ERR_O = perr_q;
`endif
  assign rx_s        = s2_q;
  assign tick        = div_q == DW'(DIV - 1);
  assign mid         = tick && tc_q == TW'(OVERSAMPLE / 2 - 1);
  assign end_bit     = tick && tc_q == TW'(OVERSAMPLE - 1);
  assign full        = cnt_q == (FIFO_AW + 1)'(DEPTH);
  assign VALID_O     = cnt_q != '0;
  assign pop         = VALID_O && READY_I;
  assign wr          = push && (!full || pop);
  assign DATA_O      = VALID_O ? mem_q[rp_q] : 8'h00;
  assign FRAME_ERR_O = ferr_q;
  assign OVERRUN_O   = ovr_q;
  // receive FSM: start detect, mid-bit sampling, stop check and push request
  always_comb begin
    st_d   = st_q;
    div_d  = tick ? '0 : div_q + 1'b1;
    tc_d   = tick ? tc_q + 1'b1 : tc_q;
    bi_d   = bi_q;
    sh_d   = sh_q;
    push   = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d = pbad_q;
    perr_d = 1'b0;
`endif
    case (st_q)
      IDLE: if (!rx_s) begin
        st_d  = START;
        div_d = '0;
        tc_d  = '0;
      end
      START: if (mid) begin
        st_d = rx_s ? IDLE : DATA;
        tc_d = '0;
        bi_d = '0;
      end
      DATA: if (end_bit) begin
        sh_d = {rx_s, sh_q[7:1]};
        tc_d = '0;
        bi_d = bi_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        st_d = bi_q == 3'd7 ? PARITY : DATA;
`else
        st_d = bi_q == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (end_bit) begin
        pbad_d = rx_s ^ (^sh_q);
        tc_d   = '0;
        st_d   = STOP;
      end
`endif
      STOP: if (end_bit) begin
        tc_d   = '0;
        st_d   = rx_s ? IDLE : BRK;
        ferr_d = !rx_s;
`ifdef UART_RX_PARITY_EN
        push   = rx_s && !pbad_q;
        perr_d = rx_s && pbad_q;
`else
        push   = rx_s;
`endif
      end
      BRK: if (rx_s) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
  // synchronizer, receiver state, FIFO pointers and error pulses
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      st_q   <= IDLE;
      div_q  <= '0;
      tc_q   <= '0;
      bi_q   <= '0;
      sh_q   <= '0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
`ifdef UART_RX_PARITY_EN
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      s1_q   <= RX_I;
      s2_q   <= s1_q;
      st_q   <= st_d;
      div_q  <= div_d;
      tc_q   <= tc_d;
      bi_q   <= bi_d;
      sh_q   <= sh_d;
      ferr_q <= ferr_d;
      ovr_q  <= push && full && !pop;
      wp_q   <= wr ? wp_q + 1'b1 : wp_q;
      rp_q   <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q  <= cnt_q + {{FIFO_AW{1'b0}}, wr} - {{FIFO_AW{1'b0}}, pop};
`ifdef UART_RX_PARITY_EN
      pbad_q <= pbad_d;
      perr_q <= perr_d;
`endif
    end
  end
  // FIFO storage; empty FIFO masks DATA_O so no reset is needed here
  always_ff @(posedge CLK_I) begin
    if (wr) mem_q[wp_q] <= sh_q;
  end
endmodule
